timer_bank: RTL and testbench

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank_pkg.sv | 27 ++
 rtl/timer_bank_if.sv | 26 ++
 rtl/timer_channel.sv | 107 ++++++++++
 rtl/timer_bank.sv | 63 ++++++
 tb/tb_timer_bank.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_bank_pkg.sv
// rtl/timer_bank_pkg.sv - shared encodings for the timer bank
package timer_bank_pkg;

  // Channel operating modes, stored in ctrl[2:1]
  typedef enum logic [1:0] {
    MODE_ONE_SHOT = 2'd0,
    MODE_AUTO     = 2'd1,
    MODE_PWM      = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  // Register targets of a bus write
  typedef enum logic [1:0] {
    REG_LOAD   = 2'd0,
    REG_CTRL   = 2'd1,
    REG_STATUS = 2'd2,
    REG_CMP    = 2'd3
  } reg_sel_e;

  // ctrl = {irq_en, mode[1:0], en}
  localparam int CTRL_W       = 4;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IRQ_EN  = 3;

endpackage

// File: rtl/timer_bank_if.sv
// rtl/timer_bank_if.sv - register write and counter read bus of timer_bank
interface timer_bank_if
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CH_W  = 2
) ();

  logic             counter_we;
  logic [CH_W-1:0]  counter_ch;
  reg_sel_e         reg_sel;
  logic [WIDTH-1:0] counter_val;
  logic [CH_W-1:0]  rd_ch;
  logic [WIDTH-1:0] counter_out;

  modport master (
    output counter_we, counter_ch, reg_sel, counter_val, rd_ch,
    input  counter_out
  );

  modport slave (
    input  counter_we, counter_ch, reg_sel, counter_val, rd_ch,
    output counter_out
  );

endinterface

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel; TIMER_BANK_PWM_EN adds the CMP register and PWM mode
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             we_load,
  input  logic             we_ctrl,
`ifdef TIMER_BANK_PWM_EN
  input  logic             we_cmp,
`endif
  input  logic [WIDTH-1:0] wdata,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             chan_out,
  output logic             expire,
  output logic             pending,
  output logic             irq_en
);

  logic [WIDTH-1:0]  load;
  logic [CTRL_W-1:0] ctrl;
  logic              tick_prev;
  mode_e             mode;
  logic              en;
  logic              tick_ev;
  logic              any_we;
  logic              dec;
  logic              expiry;

`ifdef TIMER_BANK_PWM_EN
  logic [WIDTH-1:0]  cmp;
  assign any_we = we_load | we_ctrl | we_cmp;
`else
  assign any_we = we_load | we_ctrl;
`endif

  assign en      = ctrl[CTRL_EN];
  assign mode    = mode_e'(ctrl[CTRL_MODE_HI:CTRL_MODE_LO]);
  assign irq_en  = ctrl[CTRL_IRQ_EN];
  assign tick_ev = tick & ~tick_prev;

  // A write to this channel swallows a coincident tick; a zero count never decrements
  assign dec    = !any_we && en && tick_ev && (cnt != '0) && (mode != MODE_RSVD);
  assign expiry = dec && (cnt == WIDTH'(1));

  // Counter, control, edge detect, sticky pending and output level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load      <= '0;
      cnt       <= '0;
      ctrl      <= '0;
      tick_prev <= 1'b0;
      chan_out  <= 1'b0;
      expire    <= 1'b0;
      pending   <= 1'b0;
`ifdef TIMER_BANK_PWM_EN
      cmp       <= '0;
`endif
    end else begin
      tick_prev <= tick;
      expire    <= expiry;
      if (expiry)
        pending <= 1'b1;
      else if (clr)
        pending <= 1'b0;
`ifdef TIMER_BANK_PWM_EN
      if (we_cmp)
        cmp <= wdata;
`endif
      if (we_load) begin
        load     <= wdata;
        cnt      <= wdata;
        chan_out <= 1'b0;
      end else begin
        if (we_ctrl)
          ctrl <= wdata[CTRL_W-1:0];
        if (dec) begin
          if (!expiry) begin
            cnt <= cnt - WIDTH'(1);
          end else if (mode == MODE_ONE_SHOT) begin
            cnt      <= '0;
            chan_out <= 1'b1;
          end else begin
            cnt <= load;
`ifdef TIMER_BANK_PWM_EN
            if (mode == MODE_AUTO)
              chan_out <= ~chan_out;
`else
            chan_out <= ~chan_out;
`endif
          end
        end
`ifdef TIMER_BANK_PWM_EN
        if (mode == MODE_PWM)
          chan_out <= (cnt < cmp);
`endif
        if (mode == MODE_RSVD)
          chan_out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of NUM_CH timers; TIMER_BANK_PWM_EN enables CMP writes and PWM mode
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int WIDTH  = 32,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  timer_bank_if.slave       bus,
  input  logic [NUM_CH-1:0] tick_in,
  output logic [NUM_CH-1:0] chan_out,
  output logic [NUM_CH-1:0] expire,
  output logic [NUM_CH-1:0] pending,
  output logic              irq
);

  logic [WIDTH-1:0]  cnt_arr [NUM_CH];
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] clr;
  logic [WIDTH-1:0]  rd_val;

  // Status clears are broadcast: the channel field plays no part
  assign clr = (bus.counter_we && bus.reg_sel == REG_STATUS) ? bus.counter_val[NUM_CH-1:0] : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    // Channel numbers at or above NUM_CH match no instance and are dropped
    assign hit = bus.counter_we && (bus.counter_ch == CH_W'(i));

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick_in[i]),
      .we_load  (hit && bus.reg_sel == REG_LOAD),
      .we_ctrl  (hit && bus.reg_sel == REG_CTRL),
`ifdef TIMER_BANK_PWM_EN
      .we_cmp   (hit && bus.reg_sel == REG_CMP),
`endif
      .wdata    (bus.counter_val),
      .clr      (clr[i]),
      .cnt      (cnt_arr[i]),
      .chan_out (chan_out[i]),
      .expire   (expire[i]),
      .pending  (pending[i]),
      .irq_en   (irq_en[i])
    );
  end

  // Read mux of the selected channel count, zero when out of range
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rd_ch == CH_W'(i))
        rd_val = cnt_arr[i];
    end
  end

  assign bus.counter_out = rd_val;
  assign irq = |(pending & irq_en);

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - directed self-checking bench for timer_bank
module tb_timer_bank;
  import timer_bank_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  timer_bank_if #(.WIDTH(32), .CH_W(2)) bus_a ();
  timer_bank_if #(.WIDTH(8),  .CH_W(4)) bus_b ();

  logic [2:0] tick_a, cho_a, exp_a, pend_a;
  logic       irq_a;
  logic [7:0] tick_b, cho_b, exp_b, pend_b;
  logic       irq_b;

  timer_bank #(.NUM_CH(3), .WIDTH(32), .CH_W(2)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .tick_in(tick_a),
    .chan_out(cho_a), .expire(exp_a), .pending(pend_a), .irq(irq_a)
  );

  timer_bank #(.NUM_CH(8), .WIDTH(8), .CH_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .tick_in(tick_b),
    .chan_out(cho_b), .expire(exp_b), .pending(pend_b), .irq(irq_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr_a(input int ch, input reg_sel_e sel, input logic [31:0] val);
    bus_a.counter_we  = 1'b1;
    bus_a.counter_ch  = 2'(ch);
    bus_a.reg_sel     = sel;
    bus_a.counter_val = val;
    @(negedge clk);
    bus_a.counter_we  = 1'b0;
  endtask

  task automatic wr_b(input int ch, input reg_sel_e sel, input logic [7:0] val);
    bus_b.counter_we  = 1'b1;
    bus_b.counter_ch  = 4'(ch);
    bus_b.reg_sel     = sel;
    bus_b.counter_val = val;
    @(negedge clk);
    bus_b.counter_we  = 1'b0;
  endtask

  task automatic rd_a(input int ch, output logic [31:0] v);
    bus_a.rd_ch = 2'(ch);
    #1;
    v = bus_a.counter_out;
  endtask

  task automatic rd_b(input int ch, output logic [7:0] v);
    bus_b.rd_ch = 4'(ch);
    #1;
    v = bus_b.counter_out;
  endtask

  // One tick edge on channel ch of bank A: count and pulse right after the edge, level a cycle later
  task automatic tick_one(input int ch, output logic [31:0] c, output logic e, output logic o);
    bus_a.rd_ch = 2'(ch);
    tick_a[ch] = 1'b1;
    @(negedge clk);
    c = bus_a.counter_out;
    e = exp_a[ch];
    tick_a[ch] = 1'b0;
    @(negedge clk);
    o = cho_a[ch];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  vb;
    logic [31:0] c;
    logic        e, o;
    logic [7:0]  evec, ovec;
    logic [7:0]  pwm_exp;
    int          auto_cnt [6];

    auto_cnt = '{1, 2, 1, 2, 1, 2};
    bus_a.counter_we = 0; bus_a.counter_ch = 0; bus_a.reg_sel = REG_LOAD;
    bus_a.counter_val = 0; bus_a.rd_ch = 0;
    bus_b.counter_we = 0; bus_b.counter_ch = 0; bus_b.reg_sel = REG_LOAD;
    bus_b.counter_val = 0; bus_b.rd_ch = 0;
    tick_a = 0; tick_b = 0;

    #2 rst = 1'b1;
    #1;
    check("rst_cnt", bus_a.counter_out, 0);
    check("rst_chan_out", cho_a, 0);
    check("rst_expire", exp_a, 0);
    check("rst_pending", pend_a, 0);
    check("rst_irq", irq_a, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // one-shot with irq on ch0
    wr_a(0, REG_LOAD, 3);
    rd_a(0, v);
    check("os_load", v, 3);
    wr_a(0, REG_CTRL, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      tick_one(0, c, e, o);
      check("os_cnt", c, 3 - k);
      check("os_exp", e, (k == 3));
      check("os_out", o, (k == 3));
    end
    check("os_pending", pend_a[0], 1);
    check("os_irq", irq_a, 1);
    tick_one(0, c, e, o);
    check("os_idle_cnt", c, 0);
    check("os_idle_exp", e, 0);
    check("os_hold_out", o, 1);
    wr_a(2, REG_STATUS, 32'h1);
    check("w1c_pending", pend_a[0], 0);
    check("w1c_irq", irq_a, 0);

    // auto-reload on ch1, load 2
    wr_a(1, REG_LOAD, 2);
    wr_a(1, REG_CTRL, 32'h3);
    evec = 0; ovec = 0;
    for (int k = 0; k < 6; k++) begin
      tick_one(1, c, e, o);
      check("ar_cnt", c, auto_cnt[k]);
      evec[k] = e;
      ovec[k] = o;
    end
    check("ar_expire_vec", evec, 8'b0010_1010);
    check("ar_out_vec", ovec, 8'b0010_0110);
    check("ar_irq_masked", irq_a, 0);

    // mode 2 on ch2, load 4, cmp 3
    wr_a(2, REG_CMP, 3);
    wr_a(2, REG_LOAD, 4);
    wr_a(2, REG_CTRL, 32'h5);
    evec = 0; ovec = 0;
    for (int k = 0; k < 8; k++) begin
      tick_one(2, c, e, o);
      evec[k] = e;
      ovec[k] = o;
    end
`ifdef TIMER_BANK_PWM_EN
    pwm_exp = 8'b0110_0110;
`else
    pwm_exp = 8'b0111_1000;
`endif
    check("pwm_expire_vec", evec, 8'b1000_1000);
    check("pwm_out_vec", ovec, pwm_exp);

    // write and tick edge in the same cycle: write wins
    wr_a(0, REG_LOAD, 5);
    bus_a.counter_we = 1'b1; bus_a.counter_ch = 0; bus_a.reg_sel = REG_LOAD;
    bus_a.counter_val = 9; tick_a[0] = 1'b1;
    @(negedge clk);
    bus_a.counter_we = 1'b0; tick_a[0] = 1'b0;
    check("wr_tick_exp", exp_a[0], 0);
    @(negedge clk);
    rd_a(0, v);
    check("wr_tick_cnt", v, 9);
    tick_one(0, c, e, o);
    check("after_wr_cnt", c, 8);

    // disable freezes, re-enable resumes
    wr_a(0, REG_CTRL, 32'h8);
    tick_one(0, c, e, o);
    check("frozen_cnt", c, 8);
    wr_a(0, REG_CTRL, 32'h9);
    tick_one(0, c, e, o);
    check("resume_cnt", c, 7);

    // expiry and W1C of the same bit together: set wins
    wr_a(0, REG_LOAD, 1);
    bus_a.counter_we = 1'b1; bus_a.counter_ch = 2; bus_a.reg_sel = REG_STATUS;
    bus_a.counter_val = 1; tick_a[0] = 1'b1;
    @(negedge clk);
    check("set_win_exp", exp_a[0], 1);
    check("set_win_pend", pend_a[0], 1);
    bus_a.counter_we = 1'b0; tick_a[0] = 1'b0;
    @(negedge clk);
    check("set_win_irq", irq_a, 1);

    // out-of-range channel
    wr_a(3, REG_LOAD, 77);
    rd_a(3, v);
    check("oor_read", v, 0);
    rd_a(2, v);
    check("oor_ch2_intact", v, 4);

    // eight 8-bit channels expiring together
    @(negedge clk);
    for (int i = 0; i < 8; i++) wr_b(i, REG_LOAD, 8'd255);
    for (int i = 0; i < 8; i++) wr_b(i, REG_CTRL, 8'h1);
    wr_b(9, REG_LOAD, 8'd5);
    rd_b(0, vb);
    check("b_ch0_load", vb, 255);
    rd_b(7, vb);
    check("b_ch7_load", vb, 255);
    rd_b(9, vb);
    check("b_oor_read", vb, 0);
    @(negedge clk);
    for (int t = 1; t <= 255; t++) begin
      tick_b = 8'hFF;
      @(negedge clk);
      evec = exp_b;
      tick_b = 8'h00;
      @(negedge clk);
      if (t == 254) check("b_exp_254", evec, 8'h00);
      if (t == 255) check("b_exp_255", evec, 8'hFF);
    end
    rd_b(5, vb);
    check("b_cnt_end", vb, 0);
    check("b_pending", pend_b, 8'hFF);
    check("b_chan_out", cho_b, 8'hFF);

    // reset mid-count
    @(negedge clk);
    wr_a(0, REG_LOAD, 7);
    wr_a(0, REG_CTRL, 32'h1);
    check("pre_rst_pend", pend_a, 3'b111);
    rst = 1'b1;
    #1;
    bus_a.rd_ch = 0;
    #1;
    check("mid_rst_cnt", bus_a.counter_out, 0);
    check("mid_rst_out", cho_a, 0);
    check("mid_rst_pend", pend_a, 0);
    check("mid_rst_exp", exp_a, 0);
    check("mid_rst_irq", irq_a, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tick_one(0, c, e, o);
    tick_one(0, c, e, o);
    check("post_rst_cnt", c, 0);
    check("post_rst_exp", e, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
